// File: rtl/abus_pkg.sv
// Shared types and helpers for the bus arbiter.
// Holds the FSM state enum and the priority rotate.
package abus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int MAX_N = 64;

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(
    input logic [MAX_N-1:0] v,
    input int               n
  );
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        if (i == n - 1) r[0] = v[i];
        else            r[i+1] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/abus_rr.sv
// Combinational round-robin selector.
// Picks the first requester at or above the one-hot prio bit, wrapping.
module abus_rr #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] prio_i,
  output logic [N-1:0] gnt_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dgnt;

  assign dbl   = {req_i, req_i};
  assign dgnt  = dbl & ~(dbl - {{N{1'b0}}, prio_i});
  assign gnt_o = dgnt[N-1:0] | dgnt[2*N-1:N];

endmodule

// File: rtl/abus_arb_ctrl.sv
// Bus arbiter controller: round-robin grant with
// done/abort/timeout release and rotating priority.
module abus_arb_ctrl
  import abus_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   prio_q, prio_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;

  logic [N-1:0]     arb_gnt;
  logic             arb_onehot;
  logic [MAX_N-1:0] rot_w;
  logic             own_req;
  logic             at_max;

  abus_rr #(.N(N)) u_rr (
    .req_i  (req),
    .prio_i (prio_q),
    .gnt_o  (arb_gnt)
  );

  assign arb_onehot = (arb_gnt != '0) &&
                      ((arb_gnt & (arb_gnt - N'(1))) == '0);
  assign rot_w   = rotl1(MAX_N'(grant_q), N);
  assign own_req = |(req & grant_q);
  assign at_max  = (cnt_q == CNT_MAX);

  // Next state: acquire in IDLE, hold/count/release in BUSY.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_onehot) begin
          state_d = BUSY;
          grant_d = arb_gnt;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (done || !own_req || at_max) begin
          state_d   = IDLE;
          grant_d   = '0;
          cnt_d     = '0;
          prio_d    = rot_w[N-1:0];
          timeout_d = at_max && !done;
        end else if (!at_max) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      prio_q    <= N'(1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Binary owner index from the registered one-hot grant.
  always_comb begin
    owner = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) owner = OW'(i);
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == BUSY);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_abus_arb_ctrl.sv
// Directed bench for abus_arb_ctrl, N=8 TIMEOUT=16.
// Hand-computed vectors plus per-cycle invariants.
module tb_abus_arb_ctrl;

  localparam int N  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic [2:0]   owner;
  logic         busy;
  logic         timeout;

  int n_chk = 0;
  int n_err = 0;
  bit inv_en = 1'b0;
  int hits [N];

  abus_arb_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Per-cycle invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (inv_en) begin
      chk("inv_grant_1hot0", 32'($onehot0(grant)), 32'd1);
      chk("inv_prio_1hot", 32'($onehot(dut.prio_q)), 32'd1);
      chk("inv_busy", 32'(busy), 32'(grant != '0));
    end
  end

  initial begin
    logic [N-1:0] exp_g;

    // Reset state
    do_reset();
    inv_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    chk("rst_prio", 32'(dut.prio_q), 32'h01);

    // Basic grant and done release
    req = 8'h05;
    step();
    chk("b_grant", 32'(grant), 32'h01);
    chk("b_owner", 32'(owner), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("b_rel_grant", 32'(grant), 32'h0);
    chk("b_rel_busy", 32'(busy), 32'd0);
    chk("b_rel_prio", 32'(dut.prio_q), 32'h02);
    step();
    chk("b_next_grant", 32'(grant), 32'h04);
    chk("b_next_owner", 32'(owner), 32'd2);

    // BUSY ignores other req changes
    req = 8'hFD;
    step();
    chk("hold_grant", 32'(grant), 32'h04);

    // Owner drops req: abort
    req = 8'h00;
    step();
    chk("ab_grant", 32'(grant), 32'h0);
    chk("ab_tmo", 32'(timeout), 32'd0);
    chk("ab_prio", 32'(dut.prio_q), 32'h08);

    // done in IDLE is ignored
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_done_grant", 32'(grant), 32'h0);
    chk("idle_done_prio", 32'(dut.prio_q), 32'h08);

    // Round robin with all requesting
    do_reset();
    for (int i = 0; i < N; i++) hits[i] = 0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      exp_g = 8'h01 << (k % N);
      chk("rr_grant", 32'(grant), 32'(exp_g));
      chk("rr_owner", 32'(owner), 32'(k % N));
      for (int i = 0; i < N; i++) if (grant[i]) hits[i]++;
      step();
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      chk("rr_rel", 32'(grant), 32'h0);
    end
    chk("rr_hits0", 32'(hits[0]), 32'd2);
    for (int i = 1; i < N; i++) chk("rr_hits", 32'(hits[i]), 32'd1);

    // Timeout release
    do_reset();
    req = 8'h10;
    step();
    chk("to_grant", 32'(grant), 32'h10);
    for (int c = 1; c < TO; c++) begin
      step();
      chk("to_hold", 32'(grant), 32'h10);
      chk("to_nopulse", 32'(timeout), 32'd0);
    end
    step();
    chk("to_rel_grant", 32'(grant), 32'h0);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_prio", 32'(dut.prio_q), 32'h20);
    step();
    chk("to_regrant", 32'(grant), 32'h10);
    chk("to_pulse_end", 32'(timeout), 32'd0);

    // done together with the timeout condition
    for (int c = 1; c < TO; c++) step();
    chk("dt_last_busy", 32'(busy), 32'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("dt_grant", 32'(grant), 32'h0);
    chk("dt_tmo", 32'(timeout), 32'd0);
    chk("dt_prio", 32'(dut.prio_q), 32'h20);

    // rst mid-transfer
    step();
    chk("rb_grant", 32'(grant), 32'h10);
    step();
    step();
    rst = 1'b1;
    done = 1'b1;
    step();
    chk("rb_grant0", 32'(grant), 32'h0);
    chk("rb_owner", 32'(owner), 32'd0);
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_tmo", 32'(timeout), 32'd0);
    chk("rb_prio", 32'(dut.prio_q), 32'h01);
    rst  = 1'b0;
    done = 1'b0;
    req  = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/abus_arb_ctrl.md
ABUS_ARB_CTRL -- requirements
Module: abus_arb_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, number of bus masters (N >= 2).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum ownership cycles per grant (TIMEOUT >= 2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  N  per-master bus request, level.
REQ-006 SHALL have port done  input  1  end-of-transfer strobe from the current owner, one cycle.
REQ-007 SHALL have port grant  output  N  registered one-hot ownership, all-zero when bus free.
REQ-008 SHALL have port owner  output  $clog2(N)  binary index of the granted master, 0 when free.
REQ-009 SHALL have port busy  output  1  high while in state BUSY.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL hold a registered one-hot priority vector prio, driven into an internal round-robin arbiter together with req.
REQ-012 SHALL implement FSM states IDLE and BUSY.
REQ-013 IDLE: when the arbiter grant is one-hot, SHALL load grant, owner and busy on the next edge and enter BUSY; grant is visible one cycle after req is sampled.
REQ-014 IDLE: when the arbiter grant is all-zero or not one-hot, SHALL stay in IDLE with grant = 0.
REQ-015 BUSY: grant and owner SHALL stay constant regardless of other req changes.
REQ-016 BUSY: ownership counter SHALL start at 0 on entry and increment by 1 each cycle, saturating at TIMEOUT-1.
REQ-017 BUSY: on done = 1, SHALL release: grant = 0, busy = 0, state IDLE on the next edge.
REQ-018 BUSY: on req[owner] = 0 without done (abort), SHALL release as in REQ-017.
REQ-019 BUSY: when the counter equals TIMEOUT-1 and done = 0, SHALL release as in REQ-017 and pulse timeout for exactly that next cycle.
REQ-020 Simultaneous done and timeout condition SHALL count as done (no timeout pulse); simultaneous done and req drop SHALL count as done.
REQ-021 On every release, prio SHALL be loaded with grant rotated left by one (bit N-1 wraps to bit 0), so the master after the owner is favoured next.
REQ-022 prio SHALL be unchanged outside release cycles and SHALL always be one-hot.
REQ-023 Minimum turnaround SHALL be one IDLE cycle: done at cycle m gives grant = 0 at m+1 and the earliest new grant at m+2.
REQ-024 done while in IDLE SHALL be ignored.

Reset
REQ-025 With rst = 1 at a clock edge: state IDLE, grant = 0, owner = 0, busy = 0, timeout = 0, counter = 0, prio = 1 (master 0 favoured).
REQ-026 rst asserted mid-transfer SHALL drop ownership at the next edge with no timeout pulse; rst SHALL take precedence over all other inputs.

Structure
REQ-027 The state enum and the rotate-left-by-one function SHALL live in shared package abus_pkg.
REQ-028 SHALL instantiate exactly one sub-module, abus_rr (N passed through), for combinational selection; all sequential logic SHALL be in abus_arb_ctrl.
REQ-029 Counter width SHALL be $clog2(TIMEOUT); owner SHALL be encoded from the registered grant.

Verification (N=8, TIMEOUT=16)
REQ-030 After reset, req=8'h05 -> grant=8'h01, owner=0, busy=1 one cycle later; done pulse -> grant=0 next cycle; prio=8'h02.
REQ-031 Continuous req=8'hFF with done every 3rd BUSY cycle -> grants cycle 01,02,04,...,80,01, each master granted once per 8 grants.
REQ-032 req=8'h10 held, no done -> release after 16 BUSY cycles, timeout pulses 1 cycle, prio=8'h20, grant 10 re-issued 2 cycles later.
REQ-033 Owner 8'h04 drops req mid-transfer -> grant=0 next cycle, no timeout, prio=8'h08.
REQ-034 done on cycle 16 together with the timeout condition -> release with timeout=0; rst during BUSY -> all outputs at reset values, prio=8'h01.
REQ-035 Bench SHALL assert each cycle: grant is zero or one-hot, prio is one-hot, and busy equals (grant != 0).
